// File: rtl/btb_update_ctrl_pkg.sv
// ==== btb_update_ctrl_pkg : shared BTB update types and constants (rev 1.0) ====
`default_nettype none

package btb_update_ctrl_pkg;

  // pc bit 0 never takes part in the index so compressed branches alias cleanly
  localparam int unsigned BTB_OFFSET   = 1;
  localparam int unsigned BTB_VLEN     = 64;
  localparam int unsigned BTB_IDX_BITS = 3;

  typedef struct packed {
    logic                valid;
    logic [BTB_VLEN-1:0] pc;
    logic [BTB_VLEN-1:0] target;
    logic                clear;
  } btb_upd_req_t;

  typedef struct packed {
    logic                    en;
    logic [BTB_IDX_BITS-1:0] index;
    logic                    valid;
    logic [BTB_VLEN-1:0]     target;
  } btb_wr_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } btb_upd_state_e;

endpackage

`default_nettype wire

// File: rtl/btb_upd_fifo.sv
// ==== btb_upd_fifo : update queue; tail-overwrite port only with BTB_UPD_COALESCE_EN (rev 1.0) ====
`default_nettype none

module btb_upd_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
`ifdef BTB_UPD_COALESCE_EN
  ,
  input  logic              ovr_i,
  output logic [DATA_W-1:0] tail_o,
  output logic              tail_avail_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q, rptr_q;
  logic              do_push, do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the indices match
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

`ifdef BTB_UPD_COALESCE_EN
  logic [AW:0] count;
  logic [AW:0] tail_ptr;
  assign count    = wptr_q - rptr_q;
  assign tail_ptr = wptr_q - 1'b1;
  assign tail_o   = mem_q[tail_ptr[AW-1:0]];
  // The tail may only be rewritten if it is not leaving the queue this cycle
  assign tail_avail_o = (count > (AW+1)'(1)) | (~empty_o & ~pop_i);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      mem_q[wptr_q[AW-1:0]] <= data_i;
    end
`ifdef BTB_UPD_COALESCE_EN
    else if (ovr_i && tail_avail_o && !clear_i) begin
      mem_q[tail_ptr[AW-1:0]] <= data_i;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/btb_update_ctrl.sv
// ==== btb_update_ctrl : arbitrates BTB updates, drains them, sweeps on flush (rev 1.0) ====
// ==== optional: BTB_UPD_COALESCE_EN merges same-index updates into the queue tail ====
`default_nettype none

module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned VLEN       = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          debug_mode_i,
  input  logic                          bu_valid_i,
  output logic                          bu_ready_o,
  input  logic [VLEN-1:0]               bu_pc_i,
  input  logic [VLEN-1:0]               bu_target_i,
  input  logic                          bu_clear_i,
  input  logic                          cm_valid_i,
  output logic                          cm_ready_o,
  input  logic [VLEN-1:0]               cm_pc_i,
  input  logic [VLEN-1:0]               cm_target_i,
  input  logic                          cm_clear_i,
  output logic                          wr_en_o,
  output logic [$clog2(NR_ENTRIES)-1:0] wr_index_o,
  output logic                          wr_valid_o,
  output logic [VLEN-1:0]               wr_target_o,
  output logic                          busy_o
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
  localparam int unsigned ENT_W = IDX_W + 1 + VLEN;

  btb_upd_state_e   state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             rr_q, rr_d;   // 0: branch unit wins the next tie

  logic [IDX_W-1:0] bu_idx, cm_idx;
  logic [ENT_W-1:0] push_data, head;
  logic             fifo_full, fifo_empty, fifo_clr, push, pop;
  logic             bu_hit, cm_hit, bu_cap, cm_cap, both, bu_gnt, cm_gnt;
  logic             unused_pc_bits;

  assign bu_idx = bu_pc_i[IDX_W+BTB_OFFSET-1:BTB_OFFSET];
  assign cm_idx = cm_pc_i[IDX_W+BTB_OFFSET-1:BTB_OFFSET];
  assign unused_pc_bits = ^{bu_pc_i[VLEN-1:IDX_W+BTB_OFFSET], bu_pc_i[0],
                            cm_pc_i[VLEN-1:IDX_W+BTB_OFFSET], cm_pc_i[0]};

`ifdef BTB_UPD_COALESCE_EN
  logic [ENT_W-1:0] tail;
  logic             tail_avail, ovr;
  assign bu_hit = tail_avail & (tail[ENT_W-1 -: IDX_W] == bu_idx);
  assign cm_hit = tail_avail & (tail[ENT_W-1 -: IDX_W] == cm_idx);
`else
  assign bu_hit = 1'b0;
  assign cm_hit = 1'b0;
`endif

  assign bu_cap = ~fifo_full | bu_hit;
  assign cm_cap = ~fifo_full | cm_hit;
  assign both   = bu_valid_i & cm_valid_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    bu_ready_o  = 1'b0;
    cm_ready_o  = 1'b0;
    bu_gnt      = 1'b0;
    cm_gnt      = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    fifo_clr    = 1'b0;
    push_data   = '0;
    wr_en_o     = 1'b0;
    wr_index_o  = '0;
    wr_valid_o  = 1'b0;
    wr_target_o = '0;
    busy_o      = 1'b0;
`ifdef BTB_UPD_COALESCE_EN
    ovr         = 1'b0;
`endif
    unique case (state_q)
      ST_RUN: begin
        if (flush_i) begin
          // Queued updates are stale once the whole table is being invalidated
          fifo_clr = 1'b1;
          cnt_d    = '0;
          state_d  = ST_FLUSH;
        end else begin
          pop         = ~fifo_empty;
          wr_en_o     = ~fifo_empty;
          if (!fifo_empty) begin
            wr_index_o  = head[ENT_W-1 -: IDX_W];
            wr_valid_o  = head[VLEN];
            wr_target_o = head[VLEN-1:0];
          end
          bu_ready_o = bu_cap & ~(both & rr_q);
          cm_ready_o = cm_cap & ~(both & ~rr_q);
          bu_gnt     = bu_valid_i & bu_ready_o;
          cm_gnt     = cm_valid_i & cm_ready_o;
          if (both && (bu_gnt || cm_gnt)) rr_d = ~rr_q;
          if (bu_gnt) begin
            push_data = {bu_idx, ~bu_clear_i, bu_target_i};
          end else if (cm_gnt) begin
            push_data = {cm_idx, ~cm_clear_i, cm_target_i};
          end
          if ((bu_gnt || cm_gnt) && !debug_mode_i) begin
`ifdef BTB_UPD_COALESCE_EN
            if ((bu_gnt && bu_hit) || (cm_gnt && cm_hit)) ovr = 1'b1;
            else push = 1'b1;
`else
            push = 1'b1;
`endif
          end
        end
      end
      ST_FLUSH: begin
        busy_o     = 1'b1;
        wr_en_o    = 1'b1;
        wr_index_o = cnt_q;
        if (flush_i) begin
          cnt_d = '0;
        end else if (cnt_q == IDX_W'(NR_ENTRIES-1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  btb_upd_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (FIFO_DEPTH)
  ) i_upd_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (fifo_clr),
    .push_i       (push),
    .data_i       (push_data),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
`ifdef BTB_UPD_COALESCE_EN
    ,
    .ovr_i        (ovr),
    .tail_o       (tail),
    .tail_avail_o (tail_avail)
`endif
  );

endmodule

`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
// ==== tb_btb_update_ctrl : directed vector bench for btb_update_ctrl (rev 1.0) ====
`default_nettype none

module tb_btb_update_ctrl;

  localparam int unsigned NR = 8;
  localparam int unsigned FD = 4;
  localparam int unsigned VL = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0, debug_mode_i = 1'b0;
  logic          bu_valid_i = 1'b0, bu_clear_i = 1'b0, cm_valid_i = 1'b0, cm_clear_i = 1'b0;
  logic [VL-1:0] bu_pc_i = '0, bu_target_i = '0, cm_pc_i = '0, cm_target_i = '0;
  logic          bu_ready_o, cm_ready_o, wr_en_o, wr_valid_o, busy_o;
  logic [2:0]    wr_index_o;
  logic [VL-1:0] wr_target_o;

  always #5 clk_i = ~clk_i;

  btb_update_ctrl #(.NR_ENTRIES(NR), .FIFO_DEPTH(FD), .VLEN(VL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .bu_valid_i(bu_valid_i), .bu_ready_o(bu_ready_o), .bu_pc_i(bu_pc_i),
    .bu_target_i(bu_target_i), .bu_clear_i(bu_clear_i),
    .cm_valid_i(cm_valid_i), .cm_ready_o(cm_ready_o), .cm_pc_i(cm_pc_i),
    .cm_target_i(cm_target_i), .cm_clear_i(cm_clear_i),
    .wr_en_o(wr_en_o), .wr_index_o(wr_index_o), .wr_valid_o(wr_valid_o),
    .wr_target_o(wr_target_o), .busy_o(busy_o)
  );

  typedef struct {
    logic fl, dbg, bv;  logic [63:0] bpc, btg; logic bclr;
    logic cv;           logic [63:0] cpc, ctg; logic cclr;
    logic ebr, ecr, ewe; logic [2:0] eidx; logic ewv; logic [63:0] etg; logic ebusy;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  localparam logic [63:0] A1 = 64'hFFFF_0000_0000_1000, A2 = 64'hFFFF_0000_0000_2000;
  localparam logic [63:0] A3 = 64'hFFFF_0000_0000_3000, A4 = 64'hFFFF_0000_0000_4000;
  localparam logic [63:0] A5 = 64'hFFFF_0000_0000_5000;
  localparam logic [63:0] B1 = 64'h1234_5678_0000_0B10, B2 = 64'h1234_5678_0000_0B20;
  localparam logic [63:0] B3 = 64'h1234_5678_0000_0B30, B4 = 64'h1234_5678_0000_0B40;
  localparam logic [63:0] B5 = 64'h1234_5678_0000_0B50;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic fl, dbg, bv, input logic [63:0] bpc, btg, input logic bclr,
                     input logic cv, input logic [63:0] cpc, ctg, input logic cclr,
                     input logic ebr, ecr, ewe, input logic [2:0] eidx, input logic ewv,
                     input logic [63:0] etg, input logic ebusy);
    vec_t v;
    v.fl = fl; v.dbg = dbg; v.bv = bv; v.bpc = bpc; v.btg = btg; v.bclr = bclr;
    v.cv = cv; v.cpc = cpc; v.ctg = ctg; v.cclr = cclr;
    v.ebr = ebr; v.ecr = ecr; v.ewe = ewe; v.eidx = eidx; v.ewv = ewv; v.etg = etg;
    v.ebusy = ebusy;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    flush_i = v.fl; debug_mode_i = v.dbg;
    bu_valid_i = v.bv; bu_pc_i = v.bpc; bu_target_i = v.btg; bu_clear_i = v.bclr;
    cm_valid_i = v.cv; cm_pc_i = v.cpc; cm_target_i = v.ctg; cm_clear_i = v.cclr;
  endtask

  task automatic idle_inputs();
    flush_i = 0; debug_mode_i = 0; bu_valid_i = 0; cm_valid_i = 0;
    bu_clear_i = 0; cm_clear_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int writes;

    // fl dbg | bv bpc btg bclr | cv cpc ctg cclr | ebr ecr ewe eidx ewv etg ebusy
    add(0,0, 0,0,0,0,                    0,0,0,0,         1,1, 0,0,0,0,0);
    add(0,0, 1,64'h8000_0006,64'h8000_0100,0, 0,0,0,0,    1,1, 0,0,0,0,0);
    add(0,0, 0,0,0,0,                    0,0,0,0,         1,1, 1,3,1,64'h8000_0100,0);
    add(0,0, 1,64'h10,A1,0,              1,64'h12,B1,1,   1,0, 0,0,0,0,0);
    add(0,0, 1,64'h14,A2,0,              1,64'h12,B1,1,   0,1, 1,0,1,A1,0);
    add(0,0, 1,64'h14,A2,0,              1,64'h16,B2,0,   1,0, 1,1,0,B1,0);
    add(0,0, 1,64'h18,A3,0,              1,64'h16,B2,0,   0,1, 1,2,1,A2,0);
    add(0,0, 0,0,0,0,                    0,0,0,0,         1,1, 1,3,1,B2,0);
    add(0,0, 0,0,0,0,                    1,64'h1E,B3,0,   1,1, 0,0,0,0,0);
    add(0,0, 1,64'h18,A3,0,              1,64'h02,B4,0,   1,0, 1,7,1,B3,0);
    add(0,0, 0,0,0,0,                    0,0,0,0,         1,1, 1,4,1,A3,0);
    add(0,1, 0,0,0,0,                    1,64'h04,B5,1,   1,1, 0,0,0,0,0);
    add(0,0, 0,0,0,0,                    0,0,0,0,         1,1, 0,0,0,0,0);
    add(0,0, 1,64'h06,A4,0,              0,0,0,0,         1,1, 0,0,0,0,0);
    add(1,0, 1,64'h08,A5,0,              0,0,0,0,         0,0, 0,0,0,0,0);
    for (int k = 0; k < 8; k++)
      add(0,0, 1,64'h08,A5,0,            0,0,0,0,         0,0, 1,3'(k),0,0,1);
    add(0,0, 0,0,0,0,                    0,0,0,0,         1,1, 0,0,0,0,0);
    add(1,0, 0,0,0,0,                    0,0,0,0,         0,0, 0,0,0,0,0);
    for (int k = 0; k < 6; k++)
      add((k == 5),0, 0,0,0,0,           0,0,0,0,         0,0, 1,3'(k),0,0,1);
    for (int k = 0; k < 8; k++)
      add(0,0, 0,0,0,0,                  0,0,0,0,         0,0, 1,3'(k),0,0,1);
    add(0,0, 0,0,0,0,                    0,0,0,0,         1,1, 0,0,0,0,0);

    // Reset state
    idle_inputs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset.wr_en", wr_en_o, 0);
    chk("reset.busy", busy_o, 0);
    chk("reset.wr_index", wr_index_o, 0);
    chk("reset.wr_valid", wr_valid_o, 0);
    chk("reset.wr_target", wr_target_o, 0);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk_i); #1;
      apply(vecs[i]);
      @(negedge clk_i);
      chk($sformatf("v%0d.bu_ready", i), bu_ready_o, vecs[i].ebr);
      chk($sformatf("v%0d.cm_ready", i), cm_ready_o, vecs[i].ecr);
      chk($sformatf("v%0d.wr_en", i), wr_en_o, vecs[i].ewe);
      chk($sformatf("v%0d.busy", i), busy_o, vecs[i].ebusy);
      if (vecs[i].ewe) begin
        chk($sformatf("v%0d.wr_index", i), wr_index_o, vecs[i].eidx);
        chk($sformatf("v%0d.wr_valid", i), wr_valid_o, vecs[i].ewv);
        chk($sformatf("v%0d.wr_target", i), wr_target_o, vecs[i].etg);
      end
    end

    // Asynchronous reset in the middle of a sweep
    @(posedge clk_i); #1; idle_inputs(); flush_i = 1;
    @(posedge clk_i); #1; flush_i = 0;
    repeat (3) @(posedge clk_i);
    #2;
    chk("sweep.busy_before_rst", busy_o, 1);
    chk("sweep.index_before_rst", wr_index_o, 3);
    rst_ni = 1'b0; #1;
    chk("sweep_rst.wr_en", wr_en_o, 0);
    chk("sweep_rst.busy", busy_o, 0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    writes = 0;
    repeat (NR + 2) begin
      @(negedge clk_i);
      if (wr_en_o || busy_o) writes++;
    end
    chk("sweep_rst.later_writes", writes, 0);

    // Round-robin pointer favours the branch unit after reset
    @(posedge clk_i); #1;
    bu_valid_i = 1; bu_pc_i = 64'h0A; bu_target_i = A1; bu_clear_i = 0;
    cm_valid_i = 1; cm_pc_i = 64'h0C; cm_target_i = B1; cm_clear_i = 0;
    @(negedge clk_i);
    chk("rr_rst.bu_ready", bu_ready_o, 1);
    chk("rr_rst.cm_ready", cm_ready_o, 0);
    @(posedge clk_i); #1;
    bu_valid_i = 0;
    @(negedge clk_i);
    chk("rr_rst.drain_bu_idx", wr_index_o, 5);
    chk("rr_rst.drain_bu_en", wr_en_o, 1);

    // Asynchronous reset with an entry at the queue head
    @(posedge clk_i); #1;
    idle_inputs();
    chk("drain.wr_en_before_rst", wr_en_o, 1);
    chk("drain.index_before_rst", wr_index_o, 6);
    #1 rst_ni = 1'b0; #1;
    chk("drain_rst.wr_en", wr_en_o, 0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    writes = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (wr_en_o) writes++;
    end
    chk("drain_rst.later_writes", writes, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
